tl_sched_ctrl: RTL and testbench
================================

TL_SCHED_CTRL -- requirements
Module: tl_sched_ctrl

Interface
REQ-001 Parameter GREEN_MIN, default 4: minimum cycles any green/left phase is held.
REQ-002 Parameter GREEN_MAX, default 16: cycles after which a green/left phase is forced out if another request is pending.
REQ-003 Parameter YELLOW_T, default 2: exact cycles of every yellow interval.
REQ-004 Parameter ALLRED_T, default 1: exact cycles of the all-red interval (used only with TL_ALLRED_EN).
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 Ta  input  1  street A through-traffic sensor.
REQ-008 Tal  input  1  street A left-turn sensor.
REQ-009 Tb  input  1  street B through-traffic sensor.
REQ-010 Tbl  input  1  street B left-turn sensor.
REQ-011 La  output  2  street A lamp: 00 red, 01 yellow, 10 green, 11 left-arrow green.
REQ-012 Lb  output  2  street B lamp, same encoding as La.
REQ-013 phase  output  2  active or last-served phase: 0 AG, 1 AL, 2 BG, 3 BL.

Function
REQ-014 States SHALL be GRN(p), YEL(p) and, when compiled in, ARED, where p is one of AG, AL, BG, BL.
REQ-015 Lamps SHALL be: AG gives La=10; AL gives La=11; YEL of AG or AL gives La=01; Lb mirrors this for BG and BL; every non-served lamp and both lamps in ARED SHALL be 00.
REQ-016 An 8-bit dwell timer SHALL clear on every state entry and increment each cycle, saturating at 255.
REQ-017 Sensors SHALL be sampled each cycle into pending bits pend[3:0]; a high sensor sets its bit, and the bit is cleared only on the cycle its green is entered.
REQ-018 The sensor of the phase currently in GRN SHALL NOT set its pending bit.
REQ-019 If a sensor rises on the same cycle its phase's GRN is entered, clear SHALL win.
REQ-020 GRN(p) SHALL exit to YEL(p) only when dwell is at least GREEN_MIN cycles and some other pend bit is set, and either p's sensor is low or dwell has reached GREEN_MAX cycles.
REQ-021 With no other pending request, GRN(p) SHALL hold indefinitely (rest in green).
REQ-022 On YEL(p) entry, the next phase SHALL be latched as the first set pend bit in rotating order after p (AG, AL, BG, BL, wrap-around); later requests SHALL NOT change the latched target.
REQ-023 YEL(p) SHALL last exactly YELLOW_T cycles, then enter GRN(target), or ARED when compiled in.
REQ-024 phase SHALL update on GRN entry and hold through the following YEL and ARED.
REQ-025 Lamp outputs SHALL be registered or decoded purely from the state register; no sensor-to-output combinational path is permitted.

Reset
REQ-026 reset high at any clock edge, including mid-yellow or mid-ARED, SHALL force GRN(AG), dwell 0, pend 0000 and latched target AG.
REQ-027 Reset SHALL give La=10, Lb=00 and phase=0 on the cycle after the reset edge.
REQ-028 Sensors SHALL be ignored while reset is high.

Configuration
REQ-029 With macro TL_ALLRED_EN defined, every YEL(p) SHALL be followed by ARED for exactly ALLRED_T cycles and then GRN(target).
REQ-030 Without TL_ALLRED_EN, the ARED state SHALL NOT exist, YEL(p) SHALL go directly to GRN(target), and ALLRED_T SHALL be unused.

Verification
REQ-031 Reset, then no sensors for 50 cycles -> La=10, Lb=00 and phase=0 throughout.
REQ-032 From reset, Tb pulsed for 1 cycle at cycle 1 -> AG held 4 cycles, La=01 for 2 cycles, then Lb=10 and phase=2 (ARED 1 cycle earlier with TL_ALLRED_EN).
REQ-033 Ta held high, Tb high from cycle 1 -> AG held exactly 16 cycles, then yellow, then BG.
REQ-034 In AG, Tal, Tb and Tbl all set together -> served in order AL (La=11), BG, BL (Lb=11), each for at least 4 cycles with a 2-cycle yellow between each.
REQ-035 Tbl raised during YEL(AG) whose latched target is BG -> BG served first, then BL.
REQ-036 reset asserted in the 2nd yellow cycle of BG -> next cycle La=10, Lb=00, phase=0 and pend=0000.

Source files
------------

// File: rtl/tl_sched_ctrl_if.sv
// tl_sched_ctrl_if: sensor inputs and lamp/phase outputs of the traffic-light scheduler
interface tl_sched_ctrl_if;
  logic Ta, Tal, Tb, Tbl;
  logic [1:0] La, Lb, phase;
  modport master (output Ta, Tal, Tb, Tbl, input La, Lb, phase);
  modport slave (input Ta, Tal, Tb, Tbl, output La, Lb, phase);
endinterface

// File: rtl/tl_sched_ctrl.sv
// tl_sched_ctrl: four-phase traffic-light scheduler; define TL_ALLRED_EN to add an all-red interval after every yellow
module tl_sched_ctrl #(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 16,
  parameter int YELLOW_T = 2,
  parameter int ALLRED_T = 1
) (
  input logic clk,
  input logic reset,
  tl_sched_ctrl_if.slave bus
);
`ifdef TL_ALLRED_EN
  typedef enum logic [1:0] {GRN, YEL, ARED} state_t;
  localparam logic [8:0] A_T = 9'(ALLRED_T);
`else
  typedef enum logic [0:0] {GRN, YEL} state_t;
`endif
  localparam logic [8:0] G_MIN = 9'(GREEN_MIN);
  localparam logic [8:0] G_MAX = 9'(GREEN_MAX);
  localparam logic [8:0] Y_T = 9'(YELLOW_T);
  state_t st, st_n;
  logic [1:0] ph, tgt, tgt_n, first;
  logic [7:0] dwell;
  logic [8:0] d1;
  logic [3:0] pend, pend_n, sens, other;
  logic go, enter_grn;
  always_comb begin
    sens = {bus.Tbl, bus.Tb, bus.Tal, bus.Ta};
    d1 = {1'b0, dwell} + 9'd1;
    other = pend & ~(4'b0001 << ph);
    first = pend[ph + 2'd1] ? ph + 2'd1 : pend[ph + 2'd2] ? ph + 2'd2 : ph + 2'd3;
    go = (st == GRN) && (d1 >= G_MIN) && (|other) && (!sens[ph] || d1 >= G_MAX);
    st_n = st;
    tgt_n = tgt;
    enter_grn = 1'b0;
    if (st == GRN) begin
      if (go) begin
        st_n = YEL;
        tgt_n = first;
      end
    end else if (st == YEL) begin
      if (d1 == Y_T) begin
`ifdef TL_ALLRED_EN
        st_n = ARED;
`else
        st_n = GRN;
        enter_grn = 1'b1;
`endif
      end
    end
`ifdef TL_ALLRED_EN
    else if (d1 == A_T) begin
      st_n = GRN;
      enter_grn = 1'b1;
    end
`endif
    // the served phase's own sensor is masked; a green entry clears its bit even if the sensor is high
    pend_n = (pend | (sens & ~((st == GRN) ? (4'b0001 << ph) : 4'b0000)))
           & ~(enter_grn ? (4'b0001 << tgt) : 4'b0000);
    bus.La = (st == GRN && !ph[1]) ? {1'b1, ph[0]} : (st == YEL && !ph[1]) ? 2'b01 : 2'b00;
    bus.Lb = (st == GRN && ph[1]) ? {1'b1, ph[0]} : (st == YEL && ph[1]) ? 2'b01 : 2'b00;
    bus.phase = ph;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= GRN;
      ph <= 2'd0;
      tgt <= 2'd0;
      dwell <= 8'd0;
      pend <= 4'd0;
    end else begin
      st <= st_n;
      tgt <= tgt_n;
      ph <= enter_grn ? tgt : ph;
      dwell <= (st_n != st) ? 8'd0 : (dwell == 8'hff) ? dwell : dwell + 8'd1;
      pend <= pend_n;
    end
  end
endmodule

// File: tb/tb_tl_sched_ctrl.sv
// tb_tl_sched_ctrl: directed checks of the traffic-light scheduler with hand-derived lamp sequences
module tb_tl_sched_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  tl_sched_ctrl_if bus();
  tl_sched_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  int errors = 0;
  int checks = 0;
  logic [1:0] ela[$], elb[$], eph[$];
`ifdef TL_ALLRED_EN
  localparam int AR = 1;
`else
  localparam int AR = 0;
`endif
  task automatic add(input logic [1:0] la, input logic [1:0] lb, input logic [1:0] ph, input int n);
    for (int i = 0; i < n; i++) begin
      ela.push_back(la);
      elb.push_back(lb);
      eph.push_back(ph);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_sens(input logic [3:0] s);
    {bus.Tbl, bus.Tb, bus.Tal, bus.Ta} = s;
  endtask
  task automatic start();
    ela.delete();
    elb.delete();
    eph.delete();
    reset = 1'b1;
    set_sens(4'b0000);
    tick();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    start();
    checks++;
    if ({bus.La, bus.Lb, bus.phase} !== 6'b10_00_00) begin
      errors++;
      $display("FAIL reset_lamps got La=%b Lb=%b phase=%0d exp La=10 Lb=00 phase=0", bus.La, bus.Lb, bus.phase);
    end
    checks++;
    if (dut.pend !== 4'b0000 || dut.dwell !== 8'd0) begin
      errors++;
      $display("FAIL reset_state got pend=%b dwell=%0d exp pend=0000 dwell=0", dut.pend, dut.dwell);
    end
    add(2'b10, 2'b00, 2'd0, 50);
    for (int c = 0; c < ela.size(); c++) begin
      checks++;
      if ({bus.La, bus.Lb, bus.phase} !== {ela[c], elb[c], eph[c]}) begin
        errors++;
        $display("FAIL idle_rest c=%0d got La=%b Lb=%b phase=%0d exp La=%b Lb=%b phase=%0d", c, bus.La, bus.Lb, bus.phase, ela[c], elb[c], eph[c]);
      end
      tick();
    end
  endtask
  task automatic test_min_green();
    start();
    add(2'b10, 2'b00, 2'd0, 4);
    add(2'b01, 2'b00, 2'd0, 2);
    add(2'b00, 2'b00, 2'd0, AR);
    add(2'b00, 2'b10, 2'd2, 6);
    for (int c = 0; c < ela.size(); c++) begin
      set_sens(c == 1 ? 4'b0100 : 4'b0000);
      checks++;
      if ({bus.La, bus.Lb, bus.phase} !== {ela[c], elb[c], eph[c]}) begin
        errors++;
        $display("FAIL min_green c=%0d got La=%b Lb=%b phase=%0d exp La=%b Lb=%b phase=%0d", c, bus.La, bus.Lb, bus.phase, ela[c], elb[c], eph[c]);
      end
      tick();
    end
  endtask
  task automatic test_max_green();
    start();
    add(2'b10, 2'b00, 2'd0, 16);
    add(2'b01, 2'b00, 2'd0, 2);
    add(2'b00, 2'b00, 2'd0, AR);
    add(2'b00, 2'b10, 2'd2, 4);
    for (int c = 0; c < ela.size(); c++) begin
      set_sens(c == 0 ? 4'b0001 : 4'b0101);
      checks++;
      if ({bus.La, bus.Lb, bus.phase} !== {ela[c], elb[c], eph[c]}) begin
        errors++;
        $display("FAIL max_green c=%0d got La=%b Lb=%b phase=%0d exp La=%b Lb=%b phase=%0d", c, bus.La, bus.Lb, bus.phase, ela[c], elb[c], eph[c]);
      end
      if (c == 18 + AR) begin
        checks++;
        if (dut.pend[2] !== 1'b0) begin
          errors++;
          $display("FAIL clear_wins got pend[2]=%b exp 0", dut.pend[2]);
        end
      end
      tick();
    end
    set_sens(4'b0000);
  endtask
  task automatic test_sequence();
    start();
    add(2'b10, 2'b00, 2'd0, 4);
    add(2'b01, 2'b00, 2'd0, 2);
    add(2'b00, 2'b00, 2'd0, AR);
    add(2'b11, 2'b00, 2'd1, 4);
    add(2'b01, 2'b00, 2'd1, 2);
    add(2'b00, 2'b00, 2'd1, AR);
    add(2'b00, 2'b10, 2'd2, 4);
    add(2'b00, 2'b01, 2'd2, 2);
    add(2'b00, 2'b00, 2'd2, AR);
    add(2'b00, 2'b11, 2'd3, 6);
    for (int c = 0; c < ela.size(); c++) begin
      set_sens(c == 1 ? 4'b1110 : 4'b0000);
      checks++;
      if ({bus.La, bus.Lb, bus.phase} !== {ela[c], elb[c], eph[c]}) begin
        errors++;
        $display("FAIL sequence c=%0d got La=%b Lb=%b phase=%0d exp La=%b Lb=%b phase=%0d", c, bus.La, bus.Lb, bus.phase, ela[c], elb[c], eph[c]);
      end
      tick();
    end
  endtask
  task automatic test_late_request();
    start();
    add(2'b10, 2'b00, 2'd0, 4);
    add(2'b01, 2'b00, 2'd0, 2);
    add(2'b00, 2'b00, 2'd0, AR);
    add(2'b00, 2'b10, 2'd2, 4);
    add(2'b00, 2'b01, 2'd2, 2);
    add(2'b00, 2'b00, 2'd2, AR);
    add(2'b00, 2'b11, 2'd3, 4);
    for (int c = 0; c < ela.size(); c++) begin
      set_sens(c == 1 ? 4'b0100 : c == 4 ? 4'b1000 : 4'b0000);
      checks++;
      if ({bus.La, bus.Lb, bus.phase} !== {ela[c], elb[c], eph[c]}) begin
        errors++;
        $display("FAIL late_request c=%0d got La=%b Lb=%b phase=%0d exp La=%b Lb=%b phase=%0d", c, bus.La, bus.Lb, bus.phase, ela[c], elb[c], eph[c]);
      end
      tick();
    end
  endtask
  task automatic test_reset_yellow();
    start();
    add(2'b10, 2'b00, 2'd0, 4);
    add(2'b01, 2'b00, 2'd0, 2);
    add(2'b00, 2'b00, 2'd0, AR);
    add(2'b00, 2'b10, 2'd2, 4);
    add(2'b00, 2'b01, 2'd2, 1);
    for (int c = 0; c < ela.size(); c++) begin
      set_sens(c == 1 ? 4'b0100 : c == 7 + AR ? 4'b0001 : 4'b0000);
      checks++;
      if ({bus.La, bus.Lb, bus.phase} !== {ela[c], elb[c], eph[c]}) begin
        errors++;
        $display("FAIL reset_yellow_pre c=%0d got La=%b Lb=%b phase=%0d exp La=%b Lb=%b phase=%0d", c, bus.La, bus.Lb, bus.phase, ela[c], elb[c], eph[c]);
      end
      tick();
    end
    checks++;
    if ({bus.La, bus.Lb, bus.phase} !== 6'b00_01_10) begin
      errors++;
      $display("FAIL second_yellow got La=%b Lb=%b phase=%0d exp La=00 Lb=01 phase=2", bus.La, bus.Lb, bus.phase);
    end
    reset = 1'b1;
    set_sens(4'b1111);
    tick();
    reset = 1'b0;
    set_sens(4'b0000);
    checks++;
    if ({bus.La, bus.Lb, bus.phase} !== 6'b10_00_00) begin
      errors++;
      $display("FAIL reset_mid_yellow got La=%b Lb=%b phase=%0d exp La=10 Lb=00 phase=0", bus.La, bus.Lb, bus.phase);
    end
    checks++;
    if (dut.pend !== 4'b0000 || dut.dwell !== 8'd0 || dut.tgt !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_yellow_state got pend=%b dwell=%0d tgt=%0d exp pend=0000 dwell=0 tgt=0", dut.pend, dut.dwell, dut.tgt);
    end
  endtask
  initial begin
    set_sens(4'b0000);
    test_reset();
    test_min_green();
    test_max_green();
    test_sequence();
    test_late_request();
    test_reset_yellow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
